// File: rtl/harris_corners_and_nonmax.sv
// harris_corners_and_nonmax: streaming Harris corner detector with 3x3 non-maximum suppression
module harris_corners_and_nonmax #(
    parameter int LUMA_BITS         = 8,
    parameter int MAX_IMAGE_WIDTH   = 2048,
    parameter int MATRIX_BITS       = 16,
    parameter int NONMAX_SCORE_BITS = 16,
    parameter int THRESHOLD         = 1000,
    parameter int COORD_BITS        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COORD_BITS-1:0] r_width,
    input  logic                  in_valid,
    input  logic [LUMA_BITS-1:0]  in_window [3][3],
    output logic                  out_is_corner
);
    localparam int GB  = LUMA_BITS + 3;
    localparam int PB  = 2 * GB;
    localparam int ACC = PB + 5;
    localparam int MB  = MATRIX_BITS;
    localparam int SB  = NONMAX_SCORE_BITS;
    localparam int SH  = ACC > MB ? ACC - MB : 0;
    localparam int RB  = 2 * MB + 3;
    localparam int AW  = $clog2(MAX_IMAGE_WIDTH);
    localparam int PAD = 9;
    localparam logic signed [ACC-1:0] SAT_MAX   = ACC'((1 << (MB - 1)) - 1);
    localparam logic signed [RB-1:0]  SCORE_MAX = RB'((1 << SB) - 1);

    function automatic logic [GB-1:0] px(input logic [LUMA_BITS-1:0] v);
        return GB'(v);
    endfunction

    function automatic logic signed [MB-1:0] scale(input logic signed [ACC-1:0] v);
        logic signed [ACC-1:0] s;
        s = v >>> SH;
        return s > SAT_MAX ? MB'(SAT_MAX) : s < ~SAT_MAX ? MB'(~SAT_MAX) : MB'(s);
    endfunction

    logic [LUMA_BITS-1:0] unused_centre;
    assign unused_centre = in_window[1][1];

    logic [AW-1:0] col;
    // column pointer shared by every line buffer; wraps at r_width
    always_ff @(posedge clk)
        if (reset) col <= '0;
        else if (in_valid) col <= (COORD_BITS'(col) == r_width - COORD_BITS'(1)) ? '0 : col + AW'(1);

    logic signed [GB-1:0] ix, iy;
    logic signed [PB-1:0] xx, yy, xy;
    // Sobel gradients, then their full-precision products
    always_ff @(posedge clk)
        if (reset) begin
            ix <= '0;
            iy <= '0;
            xx <= '0;
            yy <= '0;
            xy <= '0;
        end else if (in_valid) begin
            ix <= $signed(px(in_window[0][2]) + (px(in_window[1][2]) << 1) + px(in_window[2][2])
                        - px(in_window[0][0]) - (px(in_window[1][0]) << 1) - px(in_window[2][0]));
            iy <= $signed(px(in_window[2][0]) + (px(in_window[2][1]) << 1) + px(in_window[2][2])
                        - px(in_window[0][0]) - (px(in_window[0][1]) << 1) - px(in_window[0][2]));
            xx <= PB'(ix) * PB'(ix);
            yy <= PB'(iy) * PB'(iy);
            xy <= PB'(ix) * PB'(iy);
        end

    logic [3*PB-1:0] bmem [4][MAX_IMAGE_WIDTH];
    logic [3*PB-1:0] btap [4];
    logic [3*PB-1:0] bcur;
    logic signed [ACC-1:0] cs_n [3];
    logic signed [ACC-1:0] cs [3];
    logic signed [ACC-1:0] hs [4][3];
    logic signed [ACC-1:0] box [3];
    assign bcur = {xy, yy, xx};

    // five-row column sums: current product row plus four buffered rows
    always_comb begin
        for (int k = 0; k < 4; k++) btap[k] = bmem[k][col];
        for (int q = 0; q < 3; q++) begin
            cs_n[q] = ACC'($signed(bcur[q*PB +: PB]));
            for (int k = 0; k < 4; k++) cs_n[q] = cs_n[q] + ACC'($signed(btap[k][q*PB +: PB]));
        end
    end

    // product line buffers, each row read before being overwritten by the row below
    always_ff @(posedge clk)
        if (in_valid) begin
            bmem[0][col] <= bcur;
            for (int k = 1; k < 4; k++) bmem[k][col] <= btap[k-1];
        end

    // column sum register, four-column history and the 5x5 box total
    always_ff @(posedge clk)
        if (reset) begin
            for (int q = 0; q < 3; q++) begin
                cs[q]  <= '0;
                box[q] <= '0;
                for (int k = 0; k < 4; k++) hs[k][q] <= '0;
            end
        end else if (in_valid) begin
            for (int q = 0; q < 3; q++) begin
                cs[q]    <= cs_n[q];
                hs[0][q] <= cs[q];
                for (int k = 1; k < 4; k++) hs[k][q] <= hs[k-1][q];
                box[q]   <= cs[q] + hs[0][q] + hs[1][q] + hs[2][q] + hs[3][q];
            end
        end

    logic signed [MB-1:0] ma, mb, mc;
    logic signed [RB-1:0] pab, pcc, pss, resp;
    logic [SB-1:0] sc;
    // scaled tensor terms, response products, Harris response and clipped score
    always_ff @(posedge clk)
        if (reset) begin
            ma   <= '0;
            mb   <= '0;
            mc   <= '0;
            pab  <= '0;
            pcc  <= '0;
            pss  <= '0;
            resp <= '0;
            sc   <= '0;
        end else if (in_valid) begin
            ma   <= scale(box[0]);
            mb   <= scale(box[1]);
            mc   <= scale(box[2]);
            pab  <= RB'(ma) * RB'(mb);
            pcc  <= RB'(mc) * RB'(mc);
            pss  <= (RB'(ma) + RB'(mb)) * (RB'(ma) + RB'(mb));
            resp <= pab - pcc - (pss >>> 4);
            sc   <= resp > RB'(THRESHOLD) ? (resp > SCORE_MAX ? SB'(SCORE_MAX) : SB'(resp)) : '0;
        end

    logic [SB-1:0] smem [2][MAX_IMAGE_WIDTH];
    logic [SB-1:0] stap [2];
    logic [SB-1:0] win [3][3];
    logic flag_n;

    // score taps one and two rows back; window is [col][row], col 2 and row 2 newest
    always_comb begin
        stap[0] = smem[0][col];
        stap[1] = smem[1][col];
        flag_n = win[1][1] != '0
              && win[1][1] > win[0][0] && win[1][1] > win[1][0] && win[1][1] > win[2][0]
              && win[1][1] > win[0][1] && win[1][1] >= win[2][1]
              && win[1][1] >= win[0][2] && win[1][1] >= win[1][2] && win[1][1] >= win[2][2];
    end

    // score line buffers feeding the suppression window
    always_ff @(posedge clk)
        if (in_valid) begin
            smem[0][col] <= sc;
            smem[1][col] <= stap[0];
        end

    logic fmem [MAX_IMAGE_WIDTH];
    logic flag, fq;
    logic [PAD-1:0] pad;

    // one-row flag delay line, read before overwrite
    always_ff @(posedge clk)
        if (in_valid) fmem[col] <= flag;

    // suppression window, flag register and fixed padding to the output
    always_ff @(posedge clk)
        if (reset) begin
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 3; r++) win[c][r] <= '0;
            flag          <= 1'b0;
            fq            <= 1'b0;
            pad           <= '0;
            out_is_corner <= 1'b0;
        end else if (in_valid) begin
            win[2][0]     <= stap[1];
            win[2][1]     <= stap[0];
            win[2][2]     <= sc;
            win[1]        <= win[2];
            win[0]        <= win[1];
            flag          <= flag_n;
            fq            <= fmem[col];
            pad           <= {pad[PAD-2:0], fq};
            out_is_corner <= pad[PAD-1];
        end
endmodule

// File: tb/tb_harris_corners_and_nonmax.sv
// tb_harris_corners_and_nonmax: scoreboard bench comparing corner flags against a reference Harris model
module tb_harris_corners_and_nonmax;
    localparam int MAXW = 64;

    typedef struct {
        bit care;
        bit val;
        int x;
        int y;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] r_width = 16'd32;
    logic [7:0]  in_window [3][3];
    logic        out_is_corner;

    int   errors = 0;
    int   checks = 0;
    int   corners;
    int   c2;
    int   gxx [MAXW][MAXW];
    int   gyy [MAXW][MAXW];
    int   gxy [MAXW][MAXW];
    int   score_m [MAXW][MAXW];
    bit   flag_m [MAXW][MAXW];
    exp_t q [$];

    harris_corners_and_nonmax dut (
        .clk(clk),
        .reset(reset),
        .r_width(r_width),
        .in_valid(in_valid),
        .in_window(in_window),
        .out_is_corner(out_is_corner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pix(input int kind, input int sq, input int w, input int h, input int x, input int y);
        if (x < 0 || y < 0 || x >= w || y >= h) return 0;
        if (kind == 0) return 128;
        if (kind == 1) return (x >= sq && x < sq + 8 && y >= sq && y < sq + 8) ? 255 : 0;
        return x < 16 ? 0 : 255;
    endfunction

    function automatic int sat16(input int v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction

    task automatic build_model(input int kind, input int sq, input int w, input int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                int gx, gy;
                gx = pix(kind, sq, w, h, x+1, y-1) + 2*pix(kind, sq, w, h, x+1, y) + pix(kind, sq, w, h, x+1, y+1)
                   - pix(kind, sq, w, h, x-1, y-1) - 2*pix(kind, sq, w, h, x-1, y) - pix(kind, sq, w, h, x-1, y+1);
                gy = pix(kind, sq, w, h, x-1, y+1) + 2*pix(kind, sq, w, h, x, y+1) + pix(kind, sq, w, h, x+1, y+1)
                   - pix(kind, sq, w, h, x-1, y-1) - 2*pix(kind, sq, w, h, x, y-1) - pix(kind, sq, w, h, x+1, y-1);
                gxx[y][x] = gx * gx;
                gyy[y][x] = gy * gy;
                gxy[y][x] = gx * gy;
            end
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                int a, b, c;
                longint r;
                a = 0; b = 0; c = 0;
                for (int dy = -2; dy <= 2; dy++)
                    for (int dx = -2; dx <= 2; dx++)
                        if (y+dy >= 0 && y+dy < h && x+dx >= 0 && x+dx < w) begin
                            a += gxx[y+dy][x+dx];
                            b += gyy[y+dy][x+dx];
                            c += gxy[y+dy][x+dx];
                        end
                a = sat16(a >>> 11);
                b = sat16(b >>> 11);
                c = sat16(c >>> 11);
                r = longint'(a) * b - longint'(c) * c - ((longint'(a + b) * (a + b)) >>> 4);
                score_m[y][x] = r > 1000 ? (r > 65535 ? 65535 : int'(r)) : 0;
            end
        for (int y = 5; y < h - 5; y++)
            for (int x = 5; x < w - 5; x++) begin
                int s;
                s = score_m[y][x];
                flag_m[y][x] = s != 0
                    && s > score_m[y-1][x-1] && s > score_m[y-1][x] && s > score_m[y-1][x+1]
                    && s > score_m[y][x-1] && s >= score_m[y][x+1]
                    && s >= score_m[y+1][x-1] && s >= score_m[y+1][x] && s >= score_m[y+1][x+1];
            end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk({tag, "_reset_out"}, int'(out_is_corner), 0);
    endtask

    task automatic run(input string tag, input int kind, input int sq, input int w, input int h,
                       input bit stall, input int stop_at);
        int   n, j, cyc, found;
        bit   last_care, last_val;
        exp_t e;
        n = w * h + 4 * w + 24;
        j = 0;
        cyc = 0;
        found = 0;
        last_care = 0;
        last_val = 0;
        build_model(kind, sq, w, h);
        r_width = 16'(w);
        do_reset(tag);
        q.delete();
        while (j < n && j < stop_at) begin
            bit v;
            v = !(stall && cyc % 3 == 2);
            cyc++;
            in_valid = v;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    int idx;
                    idx = j + (r - 1) * w + (c - 1);
                    if (!v) in_window[r][c] = 8'($urandom);
                    else in_window[r][c] = (idx >= 0 && idx < w * h) ? 8'(pix(kind, sq, w, h, idx % w, idx / w)) : 8'd0;
                end
            if (v) begin
                e.x = j % w;
                e.y = j / w;
                e.care = j < w * h && e.x >= 5 && e.x < w - 5 && e.y >= 5 && e.y < h - 5;
                e.val = e.care ? flag_m[e.y][e.x] : 1'b0;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (v) begin
                j++;
                if (q.size() == 4 * w + 24) begin
                    e = q.pop_front();
                    if (e.care) begin
                        chk($sformatf("%s_px(%0d,%0d)", tag, e.x, e.y), int'(out_is_corner), int'(e.val));
                        found += int'(out_is_corner);
                    end
                    last_care = e.care;
                    last_val = e.val;
                end
            end else if (last_care) begin
                chk({tag, "_stall_hold"}, int'(out_is_corner), int'(last_val));
            end
        end
        in_valid = 1'b0;
        corners = found;
    endtask

    initial begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) in_window[r][c] = 8'd0;
        run("flat", 0, 0, 32, 32, 0, 1 << 30);
        chk("flat_corner_count", corners, 0);
        run("square", 1, 12, 32, 32, 0, 1 << 30);
        c2 = corners;
        chk("square_has_corners", int'(c2 > 0), 1);
        run("step", 2, 0, 32, 32, 0, 1 << 30);
        chk("step_corner_count", corners, 0);
        run("square_stall", 1, 12, 32, 32, 1, 1 << 30);
        chk("square_stall_count", corners, c2);
        run("square_abort", 1, 12, 32, 32, 0, 700);
        run("square_replay", 1, 12, 32, 32, 0, 1 << 30);
        chk("square_replay_count", corners, c2);
        run("square_w64", 1, 40, 64, 64, 0, 1 << 30);
        chk("square_w64_count", corners, c2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
